wb_write_port_arbiter: RTL and testbench

//  Owns the single register-file write port behind the WB stage.

---
 rtl/wb_write_port_arbiter_pkg.sv | 12 +
 rtl/wb_write_port_arbiter_if.sv | 25 ++
 rtl/wb_write_port_arbiter_fifo.sv | 45 ++++
 rtl/wb_write_port_arbiter.sv | 72 +++++++
 tb/tb_wb_write_port_arbiter.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/wb_write_port_arbiter_pkg.sv
// wb_write_port_arbiter_pkg: shared widths, defaults, FSM encoding and write-entry type
package wb_write_port_arbiter_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W = 5;
   localparam int DEF_DEPTH = 2;
   localparam int DEF_STARVE_LIMIT = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, STALL = 2'd2} state_e;
   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } wr_t;
endpackage

// File: rtl/wb_write_port_arbiter_if.sv
// wb_write_port_arbiter_if: WB, MDU and register-file write-port signals
interface wb_write_port_arbiter_if #(parameter int DEPTH = wb_write_port_arbiter_pkg::DEF_DEPTH);
   import wb_write_port_arbiter_pkg::*;
   localparam int PW = $clog2(DEPTH) + 1;
   logic              wb_reg_write;
   logic [REG_W-1:0]  wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              mdu_valid;
   logic [REG_W-1:0]  mdu_dst;
   logic [DATA_W-1:0] mdu_data;
   logic              mdu_ready;
   logic              rf_write;
   logic [REG_W-1:0]  rf_dst;
   logic [DATA_W-1:0] rf_data;
   logic              pipe_stall;
   logic [PW-1:0]     pending;
   modport slave (
      input  wb_reg_write, wb_dst, wb_data, mdu_valid, mdu_dst, mdu_data,
      output mdu_ready, rf_write, rf_dst, rf_data, pipe_stall, pending
   );
   modport master (
      output wb_reg_write, wb_dst, wb_data, mdu_valid, mdu_dst, mdu_data,
      input  mdu_ready, rf_write, rf_dst, rf_data, pipe_stall, pending
   );
endinterface

// File: rtl/wb_write_port_arbiter_fifo.sv
// wb_write_port_arbiter_fifo: DEPTH-entry synchronous FIFO of buffered MDU results
module wb_write_port_arbiter_fifo
   import wb_write_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  wr_t           din,
   output wr_t           dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   wr_t mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         count_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= din;
   end
   assign dout = mem_q[rptr_q];
   assign full = count_q == CW'(DEPTH);
   assign empty = count_q == '0;
   assign count = count_q;
endmodule

// File: rtl/wb_write_port_arbiter.sv
// wb_write_port_arbiter: shares the register-file write port between WB and buffered MDU results
module wb_write_port_arbiter
   import wb_write_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input logic clock,
   input logic reset,
   wb_write_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT) + 1;
   state_e state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic ready_q, ready_d;
   logic store, pop, full, empty;
   logic [CW-1:0] count, count_nxt;
   wr_t head, grant_w;
   wb_write_port_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(store),
      .pop(pop),
      .din(wr_t'({bus.mdu_dst, bus.mdu_data})),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_comb begin
      // r0 results are accepted from the MDU but never occupy a slot
      store = bus.mdu_valid && ready_q && bus.mdu_dst != '0 && !full;
      pop = !bus.wb_reg_write && !empty;
      grant_w = bus.wb_reg_write ? wr_t'({bus.wb_dst, bus.wb_data}) : head;
      bus.rf_write = (bus.wb_reg_write || !empty) && grant_w.dst != '0;
      bus.rf_dst = grant_w.dst;
      bus.rf_data = grant_w.data;
      count_nxt = count + CW'(store) - CW'(pop);
      ready_d = count_nxt < CW'(DEPTH);
      state_d = state_q;
      starve_d = starve_q;
      case (state_q)
         IDLE: state_d = store ? PENDING : IDLE;
         PENDING: begin
            starve_d = pop ? '0 : (&starve_q ? starve_q : starve_q + SW'(1));
            state_d = pop ? (count_nxt == '0 ? IDLE : PENDING)
                          : (starve_q == SW'(STARVE_LIMIT - 1) ? STALL : PENDING);
         end
         STALL: begin
            starve_d = pop ? '0 : starve_q;
            state_d = pop ? (count_nxt == '0 ? IDLE : PENDING) : STALL;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) starve_d = '0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         starve_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         starve_q <= starve_d;
         ready_q <= ready_d;
      end
   end
   assign bus.mdu_ready = ready_q;
   assign bus.pipe_stall = state_q == STALL;
   assign bus.pending = count;
endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// tb_wb_write_port_arbiter: directed checks of grant priority, buffering, starvation stall and reset
module tb_wb_write_port_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   wb_write_port_arbiter_if #(.DEPTH(2)) bus();
   wb_write_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic test_reset();
      bus.wb_reg_write = 1'b0; bus.wb_dst = 5'd0; bus.wb_data = 32'h0;
      bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd3; bus.mdu_data = 32'hCAFE0003;
      reset = 1'b1;
      @(posedge clock); @(posedge clock);
      @(negedge clock); reset = 1'b0; #1;
      total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
      total++; if (bus.mdu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.mdu_ready); end
      total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%b exp=0", bus.rf_write); end
      total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.pipe_stall); end
      bus.mdu_valid = 1'b0;
      @(negedge clock); #1;
      total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.mdu_ready); end
      total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL post_reset_pending got=%0d exp=0", bus.pending); end
   endtask

   task automatic test_wb_only();
      @(negedge clock);
      bus.wb_reg_write = 1'b1; bus.wb_dst = 5'b01101; bus.wb_data = 32'h12357968; #1;
      total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL wb_rf_write got=%b exp=1", bus.rf_write); end
      total++; if (bus.rf_dst !== 5'd13) begin bad++; $display("FAIL wb_rf_dst got=%0d exp=13", bus.rf_dst); end
      total++; if (bus.rf_data !== 32'h12357968) begin bad++; $display("FAIL wb_rf_data got=%h exp=12357968", bus.rf_data); end
   endtask

   task automatic test_idle_slot();
      @(negedge clock);
      bus.wb_reg_write = 1'b0; bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd7; bus.mdu_data = 32'h76543210; #1;
      total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL idle_rf_write0 got=%b exp=0", bus.rf_write); end
      total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL idle_pending0 got=%0d exp=0", bus.pending); end
      @(negedge clock);
      bus.mdu_valid = 1'b0; #1;
      total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL idle_pending1 got=%0d exp=1", bus.pending); end
      total++; if (bus.rf_write !== 1'b1 || bus.rf_dst !== 5'd7 || bus.rf_data !== 32'h76543210) begin
         bad++; $display("FAIL idle_write got=%b/%0d/%h exp=1/7/76543210", bus.rf_write, bus.rf_dst, bus.rf_data);
      end
      @(negedge clock); #1;
      total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL idle_pending_done got=%0d exp=0", bus.pending); end
      total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL idle_rf_write_done got=%b exp=0", bus.rf_write); end
   endtask

   task automatic test_priority_full();
      @(negedge clock);
      bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd1; bus.wb_data = 32'hA0000001;
      bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd8; bus.mdu_data = 32'h11111111; #1;
      total++; if (bus.rf_dst !== 5'd1 || bus.rf_write !== 1'b1) begin bad++; $display("FAIL prio_wb0 got=%b/%0d exp=1/1", bus.rf_write, bus.rf_dst); end
      total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready0 got=%b exp=1", bus.mdu_ready); end
      @(negedge clock);
      bus.wb_dst = 5'd2; bus.wb_data = 32'hA0000002; bus.mdu_dst = 5'd9; bus.mdu_data = 32'h22222222; #1;
      total++; if (bus.mdu_ready !== 1'b1 || bus.pending !== 2'd1) begin bad++; $display("FAIL prio_second got=%b/%0d exp=1/1", bus.mdu_ready, bus.pending); end
      @(negedge clock);
      bus.mdu_dst = 5'd10; bus.mdu_data = 32'h33333333; #1;
      total++; if (bus.mdu_ready !== 1'b0 || bus.pending !== 2'd2) begin bad++; $display("FAIL prio_full got=%b/%0d exp=0/2", bus.mdu_ready, bus.pending); end
      total++; if (bus.rf_dst !== 5'd2 || bus.rf_data !== 32'hA0000002) begin bad++; $display("FAIL prio_wb2 got=%0d/%h exp=2/a0000002", bus.rf_dst, bus.rf_data); end
      @(negedge clock);
      bus.mdu_valid = 1'b0; #1;
      total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL prio_stall_n3 got=%b exp=0", bus.pipe_stall); end
      @(negedge clock); #1;
      total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL prio_stall_n4 got=%b exp=0", bus.pipe_stall); end
      @(negedge clock); #1;
      total++; if (bus.pipe_stall !== 1'b1) begin bad++; $display("FAIL prio_stall_n5 got=%b exp=1", bus.pipe_stall); end
      total++; if (bus.rf_data !== 32'hA0000002 || bus.pending !== 2'd2) begin bad++; $display("FAIL prio_hold got=%h/%0d exp=a0000002/2", bus.rf_data, bus.pending); end
      @(negedge clock);
      bus.wb_reg_write = 1'b0; #1;
      total++; if (bus.pipe_stall !== 1'b1) begin bad++; $display("FAIL prio_stall_n6 got=%b exp=1", bus.pipe_stall); end
      total++; if (bus.rf_write !== 1'b1 || bus.rf_dst !== 5'd8 || bus.rf_data !== 32'h11111111) begin
         bad++; $display("FAIL prio_head got=%b/%0d/%h exp=1/8/11111111", bus.rf_write, bus.rf_dst, bus.rf_data);
      end
      @(negedge clock); #1;
      total++; if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL prio_stall_fall got=%b exp=0", bus.pipe_stall); end
      total++; if (bus.pending !== 2'd1 || bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL prio_after_pop got=%0d/%b exp=1/1", bus.pending, bus.mdu_ready); end
      total++; if (bus.rf_write !== 1'b1 || bus.rf_dst !== 5'd9 || bus.rf_data !== 32'h22222222) begin
         bad++; $display("FAIL prio_second_head got=%b/%0d/%h exp=1/9/22222222", bus.rf_write, bus.rf_dst, bus.rf_data);
      end
      @(negedge clock); #1;
      total++; if (bus.pending !== 2'd0 || bus.rf_write !== 1'b0) begin bad++; $display("FAIL prio_drained got=%0d/%b exp=0/0", bus.pending, bus.rf_write); end
   endtask

   task automatic test_r0();
      @(negedge clock);
      bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd0; bus.mdu_data = 32'hDEADBEEF; #1;
      total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", bus.mdu_ready); end
      @(negedge clock);
      bus.mdu_valid = 1'b0; #1;
      total++; if (bus.pending !== 2'd0 || bus.rf_write !== 1'b0) begin bad++; $display("FAIL r0_mdu got=%0d/%b exp=0/0", bus.pending, bus.rf_write); end
      @(negedge clock);
      bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd0; bus.wb_data = 32'hFFFFFFFF;
      bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd4; bus.mdu_data = 32'h44444444; #1;
      total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL r0_wb got=%b exp=0", bus.rf_write); end
      @(negedge clock);
      bus.wb_reg_write = 1'b0; bus.mdu_valid = 1'b0; #1;
      total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL r0_slot_pending got=%0d exp=1", bus.pending); end
      total++; if (bus.rf_write !== 1'b1 || bus.rf_dst !== 5'd4 || bus.rf_data !== 32'h44444444) begin
         bad++; $display("FAIL r0_slot_write got=%b/%0d/%h exp=1/4/44444444", bus.rf_write, bus.rf_dst, bus.rf_data);
      end
      @(negedge clock); #1;
      total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL r0_slot_drained got=%0d exp=0", bus.pending); end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clock);
      bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd3; bus.wb_data = 32'hB0000003;
      bus.mdu_valid = 1'b1; bus.mdu_dst = 5'd11; bus.mdu_data = 32'h0B0B0B0B;
      @(negedge clock);
      bus.mdu_dst = 5'd12; bus.mdu_data = 32'h0C0C0C0C;
      @(negedge clock);
      bus.mdu_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock); #1;
      total++; if (bus.pipe_stall !== 1'b1 || bus.pending !== 2'd2) begin bad++; $display("FAIL rst_pre got=%b/%0d exp=1/2", bus.pipe_stall, bus.pending); end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; bus.wb_reg_write = 1'b0; #1;
      total++; if (bus.pending !== 2'd0 || bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL rst_mid got=%0d/%b exp=0/0", bus.pending, bus.pipe_stall); end
      total++; if (bus.rf_write !== 1'b0 || bus.mdu_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_port got=%b/%b exp=0/0", bus.rf_write, bus.mdu_ready); end
      @(negedge clock); #1;
      total++; if (bus.rf_write !== 1'b0 || bus.pending !== 2'd0 || bus.mdu_ready !== 1'b1) begin
         bad++; $display("FAIL rst_after got=%b/%0d/%b exp=0/0/1", bus.rf_write, bus.pending, bus.mdu_ready);
      end
   endtask

   initial begin
      test_reset();
      test_wb_only();
      test_idle_slot();
      test_priority_full();
      test_r0();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
